traffic_sched_ctrl: RTL and testbench
=====================================

Name: traffic_sched_ctrl

Overview:
- Timing and request controller that sequences the traffic_light FSM.
- Generates the 1-second tick and qualifies the raw walkButton and Sensor inputs into clean request levels.
- Loads the duration of each light phase and signals phase expiry.
- The light FSM only decides which phase comes next; all timing and request conditioning lives here.

Parameters:
- CLK_DIV, 100000000, clk cycles per second tick (min 2).
- DEBOUNCE, 16, cycles a synchronized button level must hold before it is accepted (min 1).
- SENSOR_QUAL, 2, consecutive sec_ticks Sensor must stay high before sensor_qual asserts (min 1).
- MAIN_G, 12, main green duration in seconds.
- SIDE_G, 6, side green duration in seconds.
- YEL, 2, yellow duration in seconds.
- WALK, 3, walk duration in seconds.
- EXT, 3, seconds added to side green when sensor_qual is high; MAIN_G, SIDE_G+EXT, YEL and WALK must each be <= 15.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- walkButton  in  1  raw pedestrian button, asynchronous to clk.
- Sensor  in  1  raw side-street sensor, asynchronous to clk.
- phase_start  in  1  one-cycle pulse from the light FSM on entry to a new phase.
- phase_sel  in  2  phase being entered: 0 main green, 1 side green, 2 yellow, 3 walk; valid with phase_start.
- walk_ack  in  1  one-cycle pulse when the light FSM begins serving walk.
- sec_tick  out  1  one-cycle pulse, once per second.
- walk_pending  out  1  latched walk request.
- sensor_qual  out  1  qualified sensor level.
- phase_len  out  4  duration of the current phase, in seconds.
- seconds_passed  out  4  seconds elapsed in the current phase.
- phase_expired  out  1  one-cycle pulse when the phase has run out.

Behaviour:
- Reset (rst=0, async): all outputs 0; divider, debounce and qualify counters 0; synchronizers 0; running=0. Outputs are valid from the first clk edge after rst rises.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 and wraps; sec_tick=1 in the cycle div_cnt==CLK_DIV-1.
  - phase_start forces div_cnt to 0, so the first tick of a phase comes exactly CLK_DIV cycles after phase_start.
- Synchronizers: walkButton and Sensor each pass through 2 FFs before use; all logic below operates on the synchronized versions.
- Debounce and walk latch:
  - A stable counter counts cycles while the synchronized button equals its candidate level.
  - When the counter reaches DEBOUNCE, the debounced level updates.
  - A 0->1 transition of the debounced level sets walk_pending on the next edge.
  - walk_ack clears walk_pending; if set and clear occur in the same cycle, clear wins.
  - Holding the button produces one request only.
- Sensor qualification:
  - A qual counter increments on each sec_tick while the synchronized Sensor=1, saturating at SENSOR_QUAL.
  - sensor_qual=1 when qual==SENSOR_QUAL.
  - The synchronized Sensor going 0 clears the counter and sensor_qual on the next edge.
- Phase timing, at phase_start:
  - Set running=1 and seconds_passed=0.
  - Load phase_len: sel 0 -> MAIN_G; sel 1 -> SIDE_G+EXT if sensor_qual=1 that cycle, else SIDE_G; sel 2 -> YEL; sel 3 -> WALK.
  - phase_len is held until the next phase_start.
- Counting while running=1: each sec_tick increments seconds_passed.
- Expiry:
  - On the sec_tick where seconds_passed+1==phase_len, seconds_passed takes phase_len and phase_expired pulses in the following cycle.
  - running then clears, seconds_passed holds at phase_len, and no further expiry pulses occur until the next phase_start.
- phase_len==0: phase_expired pulses the cycle after phase_start.
- Before the first phase_start: sec_tick free-runs; seconds_passed stays 0; phase_expired never fires.
- phase_start while running: the phase restarts (divider, seconds and phase_len reloaded); no expiry is emitted for the aborted phase.
- phase_start coincident with a sec_tick: phase_start wins; the tick is not counted toward the new phase.
- Reset mid-phase: everything returns to reset values immediately; any pending walk request is lost.

Test Plan:
Bench parameters: CLK_DIV=10, DEBOUNCE=3, SENSOR_QUAL=2, defaults otherwise, 10 ns clk.
- Release rst and leave inputs idle for 50 cycles -> sec_tick every 10 cycles; seconds_passed=0, phase_expired=0, walk_pending=0.
- phase_start with sel=2 -> seconds_passed steps 1,2; phase_expired pulses once, 21 cycles after phase_start; seconds_passed holds at 2; no further pulses over the next 40 cycles.
- Hold Sensor=1 for 3 ticks, then phase_start with sel=1 -> sensor_qual=1 before phase_start; phase_len=9; expiry 91 cycles after phase_start. Repeat with Sensor=0 -> phase_len=6.
- Button glitches of 1-2 cycles -> walk_pending stays 0. A 7-cycle press -> walk_pending=1, 2+3 cycles (+1) after the press. Holding the button through walk_ack -> walk_pending=0 and not re-set.
- Second phase_start with sel=3 at seconds_passed=1 of a sel=0 phase -> phase_len=3, count restarts at 0; no expiry from the aborted phase.
- Pull rst low mid-phase with walk_pending=1 -> all outputs 0 asynchronously, before the next clk edge.

Source files
------------

// File: rtl/traffic_sched_ctrl.sv
// rtl/traffic_sched_ctrl.sv - second tick, request conditioning and phase timing for the traffic light FSM
//
// Ports:
//   clk, rst (async, active-low)
//   walkButton, Sensor       raw asynchronous inputs
//   phase_start, phase_sel   phase entry pulse and phase id from the light FSM
//   walk_ack                 light FSM has started serving walk
//   sec_tick                 one-cycle pulse per second
//   walk_pending             latched, debounced walk request
//   sensor_qual              sensor held high for SENSOR_QUAL ticks
//   phase_len                duration of the current phase, seconds
//   seconds_passed           seconds elapsed in the current phase
//   phase_expired            one-cycle pulse when the phase has run out
`timescale 1ns/1ps
module traffic_sched_ctrl #(
  parameter int CLK_DIV     = 100000000,
  parameter int DEBOUNCE    = 16,
  parameter int SENSOR_QUAL = 2,
  parameter int MAIN_G      = 12,
  parameter int SIDE_G      = 6,
  parameter int YEL         = 2,
  parameter int WALK        = 3,
  parameter int EXT         = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       walkButton,
  input  logic       Sensor,
  input  logic       phase_start,
  input  logic [1:0] phase_sel,
  input  logic       walk_ack,
  output logic       sec_tick,
  output logic       walk_pending,
  output logic       sensor_qual,
  output logic [3:0] phase_len,
  output logic [3:0] seconds_passed,
  output logic       phase_expired
);
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int DB_W  = $clog2(DEBOUNCE + 1);
  localparam int Q_W   = $clog2(SENSOR_QUAL + 1);

  logic [DIV_W-1:0] div_cnt;
  logic             btn_s1, btn_s2, sen_s1, sen_s2;
  logic             btn_cand, btn_deb, btn_deb_q;
  logic [DB_W-1:0]  db_cnt, db_next;
  logic [Q_W-1:0]   qual_cnt;
  logic             running;
  logic [3:0]       len_next;
  logic [4:0]       sp_inc;

  assign sec_tick    = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign sensor_qual = (qual_cnt == Q_W'(SENSOR_QUAL));
  assign sp_inc      = {1'b0, seconds_passed} + 5'd1;

  // Divider; phase_start realigns it so every phase gets whole seconds.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) div_cnt <= '0;
    else if (phase_start || sec_tick) div_cnt <= '0;
    else div_cnt <= div_cnt + DIV_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
      sen_s1 <= 1'b0;
      sen_s2 <= 1'b0;
    end else begin
      btn_s1 <= walkButton;
      btn_s2 <= btn_s1;
      sen_s1 <= Sensor;
      sen_s2 <= sen_s1;
    end
  end

  // A new level restarts the count at 1 because the current cycle already
  // matches it; the count saturates once the level has been accepted.
  always_comb begin
    db_next = db_cnt;
    if (btn_s2 != btn_cand) db_next = DB_W'(1);
    else if (db_cnt != DB_W'(DEBOUNCE)) db_next = db_cnt + DB_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_cand     <= 1'b0;
      db_cnt       <= '0;
      btn_deb      <= 1'b0;
      btn_deb_q    <= 1'b0;
      walk_pending <= 1'b0;
    end else begin
      btn_cand  <= btn_s2;
      db_cnt    <= db_next;
      btn_deb_q <= btn_deb;
      if (db_next == DB_W'(DEBOUNCE)) btn_deb <= btn_s2;
      // Only the rising edge of the debounced level requests, so a held
      // button cannot re-arm the request after walk_ack.
      if (walk_ack) walk_pending <= 1'b0;
      else if (btn_deb && !btn_deb_q) walk_pending <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) qual_cnt <= '0;
    else if (!sen_s2) qual_cnt <= '0;
    else if (sec_tick && !sensor_qual) qual_cnt <= qual_cnt + Q_W'(1);
  end

  always_comb begin
    case (phase_sel)
      2'd0:    len_next = 4'(MAIN_G);
      2'd1:    len_next = sensor_qual ? 4'(SIDE_G + EXT) : 4'(SIDE_G);
      2'd2:    len_next = 4'(YEL);
      default: len_next = 4'(WALK);
    endcase
  end

  // phase_start takes priority over a coincident tick, so an aborted phase
  // never reports expiry and the tick is not credited to the new phase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      running        <= 1'b0;
      phase_len      <= '0;
      seconds_passed <= '0;
      phase_expired  <= 1'b0;
    end else if (phase_start) begin
      running        <= (len_next != 4'd0);
      phase_len      <= len_next;
      seconds_passed <= '0;
      phase_expired  <= (len_next == 4'd0);
    end else if (running && sec_tick) begin
      if (sp_inc == {1'b0, phase_len}) begin
        seconds_passed <= phase_len;
        running        <= 1'b0;
        phase_expired  <= 1'b1;
      end else begin
        seconds_passed <= sp_inc[3:0];
        phase_expired  <= 1'b0;
      end
    end else begin
      phase_expired <= 1'b0;
    end
  end
endmodule

// File: tb/tb_traffic_sched_ctrl.sv
// tb/tb_traffic_sched_ctrl.sv - scoreboard bench for traffic_sched_ctrl
`timescale 1ns/1ps
module tb_traffic_sched_ctrl;
  localparam int CLK_DIV = 10;
  localparam int DEBOUNCE = 3;
  localparam int SQ = 2;
  localparam int MAIN_G = 12, SIDE_G = 6, YEL = 2, WALK = 3, EXT = 3;

  logic clk = 1'b0, rst = 1'b0, walkButton = 1'b0, Sensor = 1'b0;
  logic phase_start = 1'b0, walk_ack = 1'b0;
  logic [1:0] phase_sel = 2'd0;
  logic sec_tick, walk_pending, sensor_qual, phase_expired;
  logic [3:0] phase_len, seconds_passed;

  traffic_sched_ctrl #(
    .CLK_DIV(CLK_DIV), .DEBOUNCE(DEBOUNCE), .SENSOR_QUAL(SQ),
    .MAIN_G(MAIN_G), .SIDE_G(SIDE_G), .YEL(YEL), .WALK(WALK), .EXT(EXT)
  ) dut (
    .clk(clk), .rst(rst), .walkButton(walkButton), .Sensor(Sensor),
    .phase_start(phase_start), .phase_sel(phase_sel), .walk_ack(walk_ack),
    .sec_tick(sec_tick), .walk_pending(walk_pending), .sensor_qual(sensor_qual),
    .phase_len(phase_len), .seconds_passed(seconds_passed), .phase_expired(phase_expired)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;
  int eq[$];         // expected phase_expired cycles
  int wq[$];         // expected walk_pending rise cycles
  int tick_hist[$];  // cycles in which the model says sec_tick is high
  int anchor = 0, prev_anchor = 0;
  int cur_start = 0, cur_len = 0, prev_start = 0, prev_len = 0;
  bit cur_valid = 0, prev_valid = 0, m_pend = 0;
  int s_rise = -1, s_fall = -1;
  logic wp_prev = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic int len_of(input int sel, input bit q);
    case (sel)
      0: return MAIN_G;
      1: return q ? SIDE_G + EXT : SIDE_G;
      2: return YEL;
      default: return WALK;
    endcase
  endfunction

  // Sensor is seen two cycles after it is driven; a tick counts if the synced
  // sensor is high in its cycle and shows up one cycle later.
  function automatic bit exp_qual(input int n);
    int cnt;
    cnt = 0;
    if (s_rise < 0) return 1'b0;
    if (s_fall > s_rise && n >= s_fall + 3) return 1'b0;
    foreach (tick_hist[i])
      if (tick_hist[i] >= s_rise + 2 && tick_hist[i] <= n - 1) cnt++;
    return cnt >= SQ;
  endfunction

  always @(negedge clk) begin : mon
    int n, a, st, ln, esp;
    bit v, et;
    if (rst) begin
      n = cyc;
      a = (n < anchor) ? prev_anchor : anchor;
      et = (n >= a) && ((n - a) % CLK_DIV == CLK_DIV - 1);
      if (et) tick_hist.push_back(n);
      chk("sec_tick", int'(sec_tick), int'(et));
      v = 0; st = 0; ln = 0;
      if (cur_valid && n > cur_start) begin v = 1; st = cur_start; ln = cur_len; end
      else if (prev_valid) begin v = 1; st = prev_start; ln = prev_len; end
      esp = 0;
      if (v) begin
        esp = (n - st - 1) / CLK_DIV;
        if (esp > ln) esp = ln;
      end
      chk("phase_len", int'(phase_len), v ? ln : 0);
      chk("seconds_passed", int'(seconds_passed), esp);
      chk("sensor_qual", int'(sensor_qual), int'(exp_qual(n)));
      while (eq.size() > 0 && eq[0] < n) begin
        chk("expiry_missing", n, eq[0]);
        void'(eq.pop_front());
      end
      if (phase_expired) begin
        if (eq.size() == 0) chk("expiry_unexpected", 1, 0);
        else begin chk("expiry_cycle", n, eq[0]); void'(eq.pop_front()); end
      end
      while (wq.size() > 0 && wq[0] < n) begin
        chk("walk_missing", n, wq[0]);
        void'(wq.pop_front());
      end
      if (walk_pending && !wp_prev) begin
        if (wq.size() == 0) chk("walk_unexpected", 1, 0);
        else begin chk("walk_rise_cycle", n, wq[0]); void'(wq.pop_front()); end
      end
    end
    wp_prev = walk_pending;
  end

  task automatic start(input int sel);
    int c, len;
    @(posedge clk); #1;
    c = cyc;
    len = len_of(sel, exp_qual(c));
    while (eq.size() > 0 && eq[$] > c) void'(eq.pop_back());
    prev_valid = cur_valid; prev_start = cur_start; prev_len = cur_len;
    cur_valid = 1; cur_start = c; cur_len = len;
    eq.push_back(c + 1 + CLK_DIV * len);
    prev_anchor = anchor; anchor = c + 1;
    phase_sel = 2'(sel); phase_start = 1'b1;
    @(posedge clk); #1 phase_start = 1'b0;
  endtask

  task automatic press(input int len);
    @(posedge clk); #1;
    walkButton = 1'b1;
    if (len >= DEBOUNCE && !m_pend) begin wq.push_back(cyc + 2 + DEBOUNCE + 1); m_pend = 1; end
    repeat (len) @(posedge clk);
    #1 walkButton = 1'b0;
    repeat (10) @(posedge clk);
  endtask

  task automatic ack();
    @(posedge clk); #1 walk_ack = 1'b1; m_pend = 0;
    @(posedge clk); #1 walk_ack = 1'b0;
    chk("walk_cleared_by_ack", int'(walk_pending), 0);
  endtask

  task automatic set_sensor(input logic val);
    @(posedge clk); #1 Sensor = val;
    if (val) s_rise = cyc; else s_fall = cyc;
  endtask

  task automatic release_rst();
    @(posedge clk); #1 rst = 1'b1;
    anchor = cyc; prev_anchor = cyc;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_sec_tick"}, int'(sec_tick), 0);
    chk({tag, "_walk_pending"}, int'(walk_pending), 0);
    chk({tag, "_sensor_qual"}, int'(sensor_qual), 0);
    chk({tag, "_phase_len"}, int'(phase_len), 0);
    chk({tag, "_seconds_passed"}, int'(seconds_passed), 0);
    chk({tag, "_phase_expired"}, int'(phase_expired), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #17 chk_all_zero("reset");
    repeat (2) @(posedge clk);
    release_rst();
    repeat (50) @(posedge clk);

    // yellow phase, then 40 quiet cycles after expiry
    start(2);
    repeat (60) @(posedge clk);
    #1 chk("yel_hold", int'(seconds_passed), YEL);

    // sensor extension and plain side green
    set_sensor(1'b1);
    repeat (35) @(posedge clk);
    #1 chk("sensor_qual_before_start", int'(sensor_qual), 1);
    start(1);
    #1 chk("side_ext_len", int'(phase_len), SIDE_G + EXT);
    repeat (95) @(posedge clk);
    set_sensor(1'b0);
    repeat (5) @(posedge clk);
    start(1);
    #1 chk("side_len", int'(phase_len), SIDE_G);
    repeat (65) @(posedge clk);

    // glitches, a clean press, and a press held through walk_ack
    press(1);
    press(2);
    press(7);
    ack();
    @(posedge clk); #1 walkButton = 1'b1;
    wq.push_back(cyc + 2 + DEBOUNCE + 1); m_pend = 1;
    repeat (10) @(posedge clk);
    ack();
    repeat (15) @(posedge clk);
    #1 walkButton = 1'b0;
    repeat (10) @(posedge clk);

    // walk phase aborts a main green after one second
    start(0);
    repeat (14) @(posedge clk);
    #1 chk("abort_sp_before", int'(seconds_passed), 1);
    start(3);
    repeat (40) @(posedge clk);

    // asynchronous reset mid-phase with a pending walk request
    start(0);
    press(7);
    repeat (3) @(posedge clk);
    #1 chk("pending_before_reset", int'(walk_pending), 1);
    @(negedge clk); #2;
    eq.delete(); wq.delete(); tick_hist.delete();
    cur_valid = 0; prev_valid = 0; m_pend = 0; s_rise = -1; s_fall = -1;
    rst = 1'b0;
    #1 chk_all_zero("async_reset");
    repeat (3) @(posedge clk);
    release_rst();
    repeat (20) @(posedge clk);

    // randomized traffic against the scoreboard
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) < 3) set_sensor(~Sensor);
      if ($urandom_range(0, 9) < 3) press($urandom_range(1, 6));
      if (m_pend && $urandom_range(0, 1) == 1) ack();
      repeat ($urandom_range(4, 120)) @(posedge clk);
      start($urandom_range(0, 3));
    end
    repeat (200) @(posedge clk);
    #1;
    chk("expiry_queue_drained", eq.size(), 0);
    chk("walk_queue_drained", wq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
